// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-write scoreboard
// Reads are combinational with write-data and clear bypass; writes and busy updates land on the edge.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int REG_NUM  = 32,
   parameter int NR_READ  = 4,
   parameter int NR_WRITE = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [NR_READ*$clog2(REG_NUM)-1:0]  raddr_i,
   output logic [NR_READ*XLEN-1:0]      rdata_o,
   output logic [NR_READ-1:0]           rbusy_o,
   input  logic [NR_WRITE-1:0]          we_i,
   input  logic [NR_WRITE*$clog2(REG_NUM)-1:0] waddr_i,
   input  logic [NR_WRITE*XLEN-1:0]     wdata_i,
   input  logic [NR_WRITE-1:0]          wclr_i,
   input  logic [NR_WRITE-1:0]          iss_i,
   input  logic [NR_WRITE*$clog2(REG_NUM)-1:0] iss_addr_i,
   input  logic                         flush_i
);
   localparam int AW = $clog2(REG_NUM);

   logic [XLEN-1:0]     regs_q [REG_NUM];
   logic [XLEN-1:0]     regs_d [REG_NUM];
   logic [REG_NUM-1:0]  busy_q;
   logic [REG_NUM-1:0]  busy_d;
   logic [NR_WRITE-1:0] wr_ok;

   // A write is live only outside reset and when it does not target a hardwired x0.
   always_comb begin
      wr_ok = '0;
      for (int j = 0; j < NR_WRITE; j++) begin
         wr_ok[j] = we_i[j] && rst_n_i &&
                    !((ZERO_REG != 0) && (waddr_i[j*AW +: AW] == '0));
      end
   end

   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NR_WRITE; j++) begin
         if (wr_ok[j]) begin
            regs_d[waddr_i[j*AW +: AW]] = wdata_i[j*XLEN +: XLEN];
         end
      end
   end

   // Sets are applied after clears so a newly issued producer keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         for (int j = 0; j < NR_WRITE; j++) begin
            if (we_i[j] && wclr_i[j]) begin
               busy_d[waddr_i[j*AW +: AW]] = 1'b0;
            end
         end
         for (int j = 0; j < NR_WRITE; j++) begin
            if (iss_i[j] && !((ZERO_REG != 0) && (iss_addr_i[j*AW +: AW] == '0))) begin
               busy_d[iss_addr_i[j*AW +: AW]] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      rbusy_o = '0;
      for (int k = 0; k < NR_READ; k++) begin
         rdata_o[k*XLEN +: XLEN] = regs_q[raddr_i[k*AW +: AW]];
         rbusy_o[k]              = busy_q[raddr_i[k*AW +: AW]];
         for (int j = 0; j < NR_WRITE; j++) begin
            if (waddr_i[j*AW +: AW] == raddr_i[k*AW +: AW]) begin
               if ((BYPASS != 0) && wr_ok[j]) begin
                  rdata_o[k*XLEN +: XLEN] = wdata_i[j*XLEN +: XLEN];
               end
               if (we_i[j] && wclr_i[j]) begin
                  rbusy_o[k] = 1'b0;
               end
            end
         end
         if ((ZERO_REG != 0) && (raddr_i[k*AW +: AW] == '0)) begin
            rdata_o[k*XLEN +: XLEN] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NR   = 4;
   localparam int NW   = 2;

   logic              clk;
   logic              rst_n;
   logic [NR*AW-1:0]  raddr;
   logic [NR*XLEN-1:0] rdata;
   logic [NR-1:0]     rbusy;
   logic [NW-1:0]     we, wclr, iss;
   logic [NW*AW-1:0]  waddr, iss_addr;
   logic [NW*XLEN-1:0] wdata;
   logic              flush;

   int total = 0;
   int bad   = 0;

   regfile_mp dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .raddr_i    (raddr),
      .rdata_o    (rdata),
      .rbusy_o    (rbusy),
      .we_i       (we),
      .waddr_i    (waddr),
      .wdata_i    (wdata),
      .wclr_i     (wclr),
      .iss_i      (iss),
      .iss_addr_i (iss_addr),
      .flush_i    (flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [4:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic [4:0]  ra;
      logic [31:0] exp_now;
      logic [31:0] exp_next;
   } vec_t;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   vec_t vecs [8];
   exp_t sbq [$];

   task automatic expect_rd(input string name, input int port, input logic [31:0] data, input logic busy);
      exp_t e;
      e.name = name;
      e.port = port;
      e.data = data;
      e.busy = busy;
      sbq.push_back(e);
   endtask

   task automatic check_outputs();
      exp_t e;
      logic [31:0] got;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         got = rdata[e.port*XLEN +: XLEN];
         total++;
         if (got !== e.data) begin
            bad++;
            $display("FAIL %s rdata[%0d] got=%h want=%h", e.name, e.port, got, e.data);
         end
         total++;
         if (rbusy[e.port] !== e.busy) begin
            bad++;
            $display("FAIL %s rbusy[%0d] got=%b want=%b", e.name, e.port, rbusy[e.port], e.busy);
         end
      end
   endtask

   task automatic quiet();
      we       = '0;
      wclr     = '0;
      iss      = '0;
      flush    = 1'b0;
      waddr    = '0;
      wdata    = '0;
      iss_addr = '0;
   endtask

   task automatic set_ra(input int k, input logic [4:0] a);
      raddr[k*AW +: AW] = a;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      vecs[0] = '{2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{2'b11, 5'd7,  5'd7, 32'h1,        32'h2,        5'd7,  32'h2,        32'h2};
      vecs[2] = '{2'b01, 5'd0,  5'd0, 32'hFFFF,     32'h0,        5'd0,  32'h0,        32'h0};
      vecs[3] = '{2'b10, 5'd0,  5'd0, 32'h0,        32'hFFFF,     5'd0,  32'h0,        32'h0};
      vecs[4] = '{2'b11, 5'd31, 5'd1, 32'hA5A5A5A5, 32'h12345678, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[5] = '{2'b00, 5'd5,  5'd0, 32'h1111,     32'h0,        5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[6] = '{2'b11, 5'd5,  5'd6, 32'hCAFEF00D, 32'h77,       5'd6,  32'h77,       32'h77};
      vecs[7] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd1,  32'h12345678, 32'h12345678};

      quiet();
      raddr = '0;
      rst_n = 1'b0;
      #2;
      for (int k = 0; k < NR; k++) begin
         set_ra(k, 5'(k + 5));
         expect_rd("reset", k, 32'h0, 1'b0);
      end
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      for (int i = 0; i < 8; i++) begin
         quiet();
         we    = vecs[i].we;
         waddr = {vecs[i].wa1, vecs[i].wa0};
         wdata = {vecs[i].wd1, vecs[i].wd0};
         set_ra(i % NR, vecs[i].ra);
         expect_rd($sformatf("vec%0d_now", i), i % NR, vecs[i].exp_now, 1'b0);
         sample();
         next_cycle();
         quiet();
         expect_rd($sformatf("vec%0d_next", i), i % NR, vecs[i].exp_next, 1'b0);
         sample();
         next_cycle();
      end

      // scoreboard lifecycle on x9
      quiet();
      iss = 2'b01; iss_addr[4:0] = 5'd9;
      set_ra(0, 5'd9);
      expect_rd("iss9_same", 0, 32'h0, 1'b0);
      sample(); next_cycle();
      quiet();
      expect_rd("iss9_busy", 0, 32'h0, 1'b1);
      sample(); next_cycle();
      quiet();
      we = 2'b01; wclr = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h55;
      expect_rd("wb9_same", 0, 32'h55, 1'b0);
      sample(); next_cycle();
      quiet();
      expect_rd("wb9_next", 0, 32'h55, 1'b0);
      sample(); next_cycle();

      // set and clear of x12 in the same cycle
      quiet();
      iss = 2'b10; iss_addr[9:5] = 5'd12;
      we = 2'b01; wclr = 2'b01; waddr[4:0] = 5'd12; wdata[31:0] = 32'h99;
      set_ra(1, 5'd12);
      expect_rd("setclr12_same", 1, 32'h99, 1'b0);
      sample(); next_cycle();
      quiet();
      expect_rd("setclr12_next", 1, 32'h99, 1'b1);
      sample(); next_cycle();
      quiet();
      wclr = 2'b01; waddr[4:0] = 5'd12;
      expect_rd("wclr_no_we", 1, 32'h99, 1'b1);
      sample(); next_cycle();
      quiet();
      expect_rd("wclr_no_we_next", 1, 32'h99, 1'b1);
      sample(); next_cycle();

      // flush with a concurrent issue
      quiet();
      iss = 2'b11; iss_addr = {5'd4, 5'd3};
      next_cycle();
      quiet();
      iss = 2'b01; iss_addr[4:0] = 5'd31;
      set_ra(0, 5'd3); set_ra(1, 5'd4); set_ra(2, 5'd31); set_ra(3, 5'd6);
      expect_rd("pre_x3", 0, 32'h0, 1'b1);
      expect_rd("pre_x4", 1, 32'h0, 1'b1);
      expect_rd("pre_x31", 2, 32'hA5A5A5A5, 1'b0);
      expect_rd("pre_x6", 3, 32'h77, 1'b0);
      sample(); next_cycle();
      quiet();
      flush = 1'b1; iss = 2'b01; iss_addr[4:0] = 5'd6;
      expect_rd("flush_x3", 0, 32'h0, 1'b1);
      expect_rd("flush_x4", 1, 32'h0, 1'b1);
      expect_rd("flush_x31", 2, 32'hA5A5A5A5, 1'b1);
      expect_rd("flush_x6", 3, 32'h77, 1'b0);
      sample(); next_cycle();
      quiet();
      expect_rd("post_x3", 0, 32'h0, 1'b0);
      expect_rd("post_x4", 1, 32'h0, 1'b0);
      expect_rd("post_x31", 2, 32'hA5A5A5A5, 1'b0);
      expect_rd("post_x6", 3, 32'h77, 1'b0);
      sample(); next_cycle();

      // x0 can never become busy
      quiet();
      iss = 2'b01; iss_addr[4:0] = 5'd0;
      next_cycle();
      quiet();
      set_ra(0, 5'd0);
      expect_rd("x0_not_busy", 0, 32'h0, 1'b0);
      sample(); next_cycle();

      // asynchronous reset mid-operation
      quiet();
      iss = 2'b01; iss_addr[4:0] = 5'd20;
      next_cycle();
      quiet();
      set_ra(0, 5'd20); set_ra(1, 5'd5); set_ra(2, 5'd7); set_ra(3, 5'd31);
      expect_rd("prerst_x20", 0, 32'h0, 1'b1);
      expect_rd("prerst_x5", 1, 32'hCAFEF00D, 1'b0);
      expect_rd("prerst_x7", 2, 32'h2, 1'b0);
      expect_rd("prerst_x31", 3, 32'hA5A5A5A5, 1'b0);
      sample();
      @(posedge clk);
      #2;
      we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hBAD;
      iss = 2'b01; iss_addr[4:0] = 5'd7;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NR; k++) begin
         expect_rd($sformatf("midrst_p%0d", k), k, 32'h0, 1'b0);
      end
      check_outputs();
      @(negedge clk);
      quiet();
      rst_n = 1'b1;
      next_cycle();
      for (int k = 0; k < NR; k++) begin
         expect_rd($sformatf("postrst_p%0d", k), k, 32'h0, 1'b0);
      end
      sample();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
